// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: instruction
// field encodings, ALU operation codes, ALU operand-B selects, the main
// FSM state type and the decoded instruction class.
package mips_pkg;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field IR[5:0] for R-type
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;

    // ALU operation codes
    localparam logic [3:0] ALUOP_NONE = 4'd0;
    localparam logic [3:0] ALUOP_ADD  = 4'd2;
    localparam logic [3:0] ALUOP_SLL  = 4'd3;
    localparam logic [3:0] ALUOP_SUB  = 4'd6;

    // ALU operand-B selects
    localparam logic [1:0] ALU_SRC_B_REG   = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM   = 2'b10;
    localparam logic [1:0] ALU_SRC_B_SHAMT = 2'b11;

    // Main control FSM states
    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ADDR,
        ST_MEM,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_BRANCH
    } mc_state_e;

    // Instruction classes produced by the decoder
    typedef enum logic [2:0] {
        CL_R_ADD,
        CL_R_SLL,
        CL_ADDI,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_ILLEGAL
    } instr_class_e;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier: maps {opcode, funct} onto the
// small set of instruction classes the control FSM knows how to sequence.
// beq is only recognised when the build defines MC_BRANCH_EN; otherwise
// opcode 04 falls through to CL_ILLEGAL like any other unknown opcode.
module instr_class_decode
    import mips_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [5:0]   funct_i,
    output instr_class_e class_o
);

    // Classify the instruction; anything not listed is illegal
    always_comb begin
        class_o = CL_ILLEGAL;
        case (opcode_i)
            OP_RTYPE: begin
                if (funct_i == FN_ADD) begin
                    class_o = CL_R_ADD;
                end else if (funct_i == FN_SLL) begin
                    class_o = CL_R_SLL;
                end
            end
            OP_ADDI: class_o = CL_ADDI;
            OP_LW:   class_o = CL_LOAD;
            OP_SW:   class_o = CL_STORE;
`ifdef MC_BRANCH_EN
            OP_BEQ:  class_o = CL_BRANCH;
`endif
            default: class_o = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the MIPS core (add/addi/lw/sw/sll).
// Sequences FETCH/DECODE/EXEC/MEM/WB over one shared ALU and one shared
// memory port, with a bounded-wait watchdog on every memory access.
// Optional feature: define MC_BRANCH_EN to add beq via a BRANCH state.
// Outputs are Moore-decoded from the state register; only the strobes that
// depend on access completion (ir_write, FETCH pc_write, instr_done in MEM,
// bus_err) also look at same-cycle mem_ready / watchdog expiry.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] aluop,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic       bus_err,
    output logic       instr_done
);

    localparam int            CW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_TIMEOUT);

    mc_state_e     state_q, state_d;
    instr_class_e  cls_q, cls_d;
    instr_class_e  dec_cls;
    logic [CW-1:0] wait_q, wait_d;
    logic          run_q;
    logic          access;
    logic          expire;

`ifndef MC_BRANCH_EN
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
`endif

    instr_class_decode u_decode (
        .opcode_i (opcode),
        .funct_i  (funct),
        .class_o  (dec_cls)
    );

    // run_q keeps every output low while reset is held and until the first
    // clock edge after release, so mem_req drops asynchronously with rst_n.
    assign access = run_q && ((state_q == ST_FETCH) || (state_q == ST_MEM));
    assign expire = access && !mem_ready && (wait_q >= CNT_LAST);

    // Next-state, latched instruction class and watchdog count
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        wait_d  = '0;
        if (access && !mem_ready && !expire) begin
            wait_d = (wait_q == CNT_MAX) ? wait_q : wait_q + CW'(1);
        end
        if (run_q) begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    cls_d = dec_cls;
                    case (dec_cls)
                        CL_R_ADD, CL_R_SLL: state_d = ST_EXEC_R;
                        CL_ADDI:            state_d = ST_EXEC_I;
                        CL_LOAD, CL_STORE:  state_d = ST_ADDR;
`ifdef MC_BRANCH_EN
                        CL_BRANCH:          state_d = ST_BRANCH;
`endif
                        default:            state_d = ST_FETCH;
                    endcase
                end
                ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
                ST_ADDR:              state_d = ST_MEM;
                ST_MEM: begin
                    if (mem_ready) begin
                        state_d = (cls_q == CL_LOAD) ? ST_WB_MEM : ST_FETCH;
                    end else if (expire) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // State, class and watchdog registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            state_q <= ST_FETCH;
            cls_q   <= CL_ILLEGAL;
            wait_q  <= '0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
        end
    end

    // Moore output decode, with completion-qualified strobes
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_SRC_B_REG;
        aluop      = ALUOP_NONE;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        instr_done = 1'b0;
        if (run_q) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = ALU_SRC_B_FOUR;
                    aluop     = ALUOP_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    bus_err   = expire;
                end
                ST_DECODE: begin
                    illegal = (dec_cls == CL_ILLEGAL);
                end
                ST_EXEC_R: begin
                    alu_src_a = 1'b1;
                    if (cls_q == CL_R_SLL) begin
                        alu_src_b = ALU_SRC_B_SHAMT;
                        aluop     = ALUOP_SLL;
                    end else begin
                        alu_src_b = ALU_SRC_B_REG;
                        aluop     = ALUOP_ADD;
                    end
                end
                ST_EXEC_I, ST_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALU_SRC_B_IMM;
                    aluop     = ALUOP_ADD;
                end
                ST_MEM: begin
                    mem_req    = 1'b1;
                    iord       = 1'b1;
                    mem_we     = (cls_q == CL_STORE);
                    instr_done = mem_ready && (cls_q == CL_STORE);
                    bus_err    = expire;
                end
                ST_WB_ALU: begin
                    reg_write  = 1'b1;
                    reg_dst    = (cls_q != CL_ADDI);
                    instr_done = 1'b1;
                end
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
`ifdef MC_BRANCH_EN
                ST_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = ALU_SRC_B_REG;
                    aluop      = ALUOP_SUB;
                    pc_write   = alu_zero;
                    instr_done = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
